jtgng_rom_arb: RTL and testbench

- Shares the single game-side SDRAM read port (sdram_req/sdram_addr/sdram_ack/data_rdy/data_read) among N ROM clients: main CPU, sound CPU, char, scroll, object fetchers.
- Each client has a one-entry cache (address + 32-bit word), so repeated reads of the same address cost no SDRAM cycle.
- Misses are served one at a time, in round-robin order.
- Sits between the game's ROM fetch logic and the frame SDRAM controller. Stands down while ROM is downloading.

---
 rtl/jtgng_rom_arb.sv | 137 +++++++++++++
 tb/tb_jtgng_rom_arb.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtgng_rom_arb.sv
// Round-robin arbiter sharing one SDRAM read port among N ROM clients.
// Each client owns a one-entry cache (tag + word), so repeated reads cost no SDRAM cycle.
module jtgng_rom_arb #(
    parameter int N  = 4,
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            downloading,
    input  logic            loop_rst,
    input  logic [N-1:0]    cs,
    input  logic [N*AW-1:0] addr,
    output logic [N-1:0]    ok,
    output logic [N*DW-1:0] dout,
    output logic            sdram_req,
    output logic [AW-1:0]   sdram_addr,
    input  logic            sdram_ack,
    input  logic            data_rdy,
    input  logic [DW-1:0]   data_read,
    output logic            refresh_en
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_RDY
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr;
    logic [IW-1:0]   gnt;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   rr_next;
    logic [IW:0]     scan_idx;
    logic [N-1:0]    valid;
    logic [AW-1:0]   tag    [N];
    logic [DW-1:0]   data_q [N];
    logic [AW-1:0]   addr_a [N];
    logic [N-1:0]    hit;
    logic [N-1:0]    miss;
    logic            any_miss;
    logic            fill;

    for (genvar i = 0; i < N; i++) begin : g_client
        assign addr_a[i]        = addr[i*AW +: AW];
        assign dout[i*DW +: DW] = data_q[i];
        assign hit[i]           = cs[i] && valid[i] && (tag[i] == addr_a[i]);
    end

    assign miss     = cs & ~hit;
    assign any_miss = |miss;

    // Scan downward so the last match written is the first miss at or after rr.
    always_comb begin
        grant    = '0;
        scan_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr} + (IW+1)'(k);
            if (scan_idx >= (IW+1)'(N)) scan_idx = scan_idx - (IW+1)'(N);
            if (miss[scan_idx[IW-1:0]]) grant = scan_idx[IW-1:0];
        end
    end

    assign rr_next = (gnt == IW'(N - 1)) ? '0 : gnt + IW'(1);

    // Data may arrive together with the ack, so a fill is possible from WAIT_ACK too.
    assign fill = data_rdy && ((state == WAIT_RDY) || ((state == WAIT_ACK) && sdram_ack));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            ok         <= '0;
            refresh_en <= 1'b1;
            rr         <= '0;
            gnt        <= '0;
            valid      <= '0;
            for (int i = 0; i < N; i++) begin
                tag[i]    <= '0;
                data_q[i] <= '0;
            end
        end else if (downloading) begin
            // ROM contents are being rewritten: every cached word becomes stale.
            state      <= IDLE;
            sdram_req  <= 1'b0;
            ok         <= '0;
            refresh_en <= 1'b1;
            valid      <= '0;
        end else begin
            ok <= hit;
            if (loop_rst) begin
                state      <= IDLE;
                sdram_req  <= 1'b0;
                refresh_en <= 1'b1;
                rr         <= '0;
            end else begin
                if (fill) begin
                    valid[gnt]  <= 1'b1;
                    tag[gnt]    <= sdram_addr;
                    data_q[gnt] <= data_read;
                    rr          <= rr_next;
                end
                case (state)
                    IDLE: begin
                        refresh_en <= !any_miss;
                        if (any_miss) begin
                            sdram_addr <= addr_a[grant];
                            sdram_req  <= 1'b1;
                            gnt        <= grant;
                            state      <= WAIT_ACK;
                        end
                    end
                    WAIT_ACK: begin
                        refresh_en <= 1'b0;
                        if (sdram_ack) begin
                            sdram_req <= 1'b0;
                            state     <= data_rdy ? IDLE : WAIT_RDY;
                        end
                    end
                    WAIT_RDY: begin
                        refresh_en <= 1'b0;
                        if (data_rdy) state <= IDLE;
                    end
                    default: begin
                        state     <= IDLE;
                        sdram_req <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtgng_rom_arb.sv
// Directed self-checking bench for jtgng_rom_arb (N=4, AW=22, DW=32).
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_jtgng_rom_arb;

    localparam int N  = 4;
    localparam int AW = 22;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            downloading;
    logic            loop_rst;
    logic [N-1:0]    cs;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    ok;
    logic [N*DW-1:0] dout;
    logic            sdram_req;
    logic [AW-1:0]   sdram_addr;
    logic            sdram_ack;
    logic            data_rdy;
    logic [DW-1:0]   data_read;
    logic            refresh_en;

    int vectors     = 0;
    int miscompares = 0;

    jtgng_rom_arb #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .downloading(downloading),
        .loop_rst   (loop_rst),
        .cs         (cs),
        .addr       (addr),
        .ok         (ok),
        .dout       (dout),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .data_rdy   (data_rdy),
        .data_read  (data_read),
        .refresh_en (refresh_en)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        addr[i*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] dout_of(input int i);
        return dout[i*DW +: DW];
    endfunction

    task automatic do_reset();
        sdram_ack   = 1'b0;
        data_rdy    = 1'b0;
        downloading = 1'b0;
        loop_rst    = 1'b0;
        rst_n       = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Behaves as the controller: waits for a request, acks it, returns data one cycle later.
    task automatic serve(input logic [DW-1:0] d, output logic [AW-1:0] got, output bit timeout);
        timeout = 1'b1;
        got     = '0;
        for (int c = 0; c < 20; c++) begin
            if (sdram_req) begin
                timeout = 1'b0;
                break;
            end
            tick();
        end
        if (!timeout) begin
            got       = sdram_addr;
            sdram_ack = 1'b1;
            tick();
            sdram_ack = 1'b0;
            tick();
            data_rdy  = 1'b1;
            data_read = d;
            tick();
            data_rdy  = 1'b0;
        end
    endtask

    task automatic test_reset();
        cs   = '0;
        addr = '0;
        data_read = '0;
        do_reset();
        vectors++;
        if (sdram_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_req: got %b want 0", sdram_req); end
        vectors++;
        if (sdram_addr !== '0) begin miscompares++; $display("[TB] FAIL reset_addr: got %h want 0", sdram_addr); end
        vectors++;
        if (ok !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_ok: got %b want 0000", ok); end
        vectors++;
        if (dout !== '0) begin miscompares++; $display("[TB] FAIL reset_dout: got %h want 0", dout); end
        vectors++;
        if (refresh_en !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_refresh: got %b want 1", refresh_en); end
    endtask

    task automatic test_miss_fill();
        cs = 4'b0001;
        set_addr(0, 22'h00100);
        tick();
        vectors++;
        if (sdram_req !== 1'b1) begin miscompares++; $display("[TB] FAIL miss_req: got %b want 1", sdram_req); end
        vectors++;
        if (sdram_addr !== 22'h00100) begin miscompares++; $display("[TB] FAIL miss_addr: got %h want 00100", sdram_addr); end
        tick();
        vectors++;
        if (sdram_req !== 1'b1) begin miscompares++; $display("[TB] FAIL miss_req_hold: got %b want 1", sdram_req); end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        vectors++;
        if (sdram_req !== 1'b0) begin miscompares++; $display("[TB] FAIL miss_req_drop: got %b want 0", sdram_req); end
        tick();
        tick();
        tick();
        vectors++;
        if (ok !== 4'b0000) begin miscompares++; $display("[TB] FAIL miss_ok_early: got %b want 0000", ok); end
        data_rdy  = 1'b1;
        data_read = 32'hDEADBEEF;
        tick();
        data_rdy = 1'b0;
        vectors++;
        if (dout_of(0) !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL miss_dout: got %h want deadbeef", dout_of(0)); end
        vectors++;
        if (ok[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL miss_ok_same_cycle: got %b want 0", ok[0]); end
        tick();
        vectors++;
        if (ok !== 4'b0001) begin miscompares++; $display("[TB] FAIL miss_ok_after: got %b want 0001", ok); end
        vectors++;
        if (refresh_en !== 1'b1) begin miscompares++; $display("[TB] FAIL miss_refresh_back: got %b want 1", refresh_en); end
    endtask

    task automatic test_hit_reuse();
        cs = 4'b0000;
        tick();
        vectors++;
        if (ok !== 4'b0000) begin miscompares++; $display("[TB] FAIL hit_cs_drop: got %b want 0000", ok); end
        cs = 4'b0001;
        tick();
        vectors++;
        if (ok !== 4'b0001) begin miscompares++; $display("[TB] FAIL hit_ok: got %b want 0001", ok); end
        vectors++;
        if (sdram_req !== 1'b0) begin miscompares++; $display("[TB] FAIL hit_no_req: got %b want 0", sdram_req); end
        tick();
        vectors++;
        if (sdram_req !== 1'b0) begin miscompares++; $display("[TB] FAIL hit_no_req2: got %b want 0", sdram_req); end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] got;
        bit            to;
        logic [AW-1:0] exp_a [8];
        exp_a = '{22'h010, 22'h011, 22'h012, 22'h013, 22'h021, 22'h022, 22'h030, 22'h032};
        for (int i = 0; i < N; i++) set_addr(i, exp_a[i]);
        cs = 4'b1111;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            serve(32'hA0000000 + 32'(k), got, to);
            vectors++;
            if (to || got !== exp_a[k]) begin
                miscompares++;
                $display("[TB] FAIL rr_round1_%0d: got %h timeout=%0d want %h", k, got, to, exp_a[k]);
            end
        end
        tick();
        vectors++;
        if (ok !== 4'b1111) begin miscompares++; $display("[TB] FAIL rr_all_ok: got %b want 1111", ok); end
        vectors++;
        if (dout_of(3) !== 32'hA0000003) begin miscompares++; $display("[TB] FAIL rr_dout3: got %h want a0000003", dout_of(3)); end
        // rr is 0: clients 1 and 2 miss, so 1 goes first
        set_addr(1, 22'h021);
        set_addr(2, 22'h022);
        for (int k = 4; k < 6; k++) begin
            serve(32'hB0000000 + 32'(k), got, to);
            vectors++;
            if (to || got !== exp_a[k]) begin
                miscompares++;
                $display("[TB] FAIL rr_round2_%0d: got %h timeout=%0d want %h", k, got, to, exp_a[k]);
            end
        end
        tick();
        // rr is 3: client 3 hits, scan wraps to client 0 before client 2
        set_addr(0, 22'h030);
        set_addr(2, 22'h032);
        for (int k = 6; k < 8; k++) begin
            serve(32'hC0000000 + 32'(k), got, to);
            vectors++;
            if (to || got !== exp_a[k]) begin
                miscompares++;
                $display("[TB] FAIL rr_wrap_%0d: got %h timeout=%0d want %h", k, got, to, exp_a[k]);
            end
        end
        tick();
        vectors++;
        if (ok !== 4'b1111) begin miscompares++; $display("[TB] FAIL rr_final_ok: got %b want 1111", ok); end
    endtask

    task automatic test_addr_change();
        cs = 4'b0010;
        set_addr(1, 22'h200);
        do_reset();
        tick();
        vectors++;
        if (sdram_req !== 1'b1 || sdram_addr !== 22'h200) begin
            miscompares++;
            $display("[TB] FAIL chg_req: got req=%b addr=%h want req=1 addr=00200", sdram_req, sdram_addr);
        end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        set_addr(1, 22'h300);
        tick();
        data_rdy  = 1'b1;
        data_read = 32'h11112222;
        tick();
        data_rdy = 1'b0;
        vectors++;
        if (dout_of(1) !== 32'h11112222) begin miscompares++; $display("[TB] FAIL chg_old_fill: got %h want 11112222", dout_of(1)); end
        tick();
        vectors++;
        if (ok !== 4'b0000) begin miscompares++; $display("[TB] FAIL chg_ok_low: got %b want 0000", ok); end
        vectors++;
        if (sdram_req !== 1'b1 || sdram_addr !== 22'h300) begin
            miscompares++;
            $display("[TB] FAIL chg_rearb: got req=%b addr=%h want req=1 addr=00300", sdram_req, sdram_addr);
        end
        // ack and data together while waiting for the ack
        sdram_ack = 1'b1;
        data_rdy  = 1'b1;
        data_read = 32'h33334444;
        tick();
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        vectors++;
        if (sdram_req !== 1'b0) begin miscompares++; $display("[TB] FAIL same_cycle_req: got %b want 0", sdram_req); end
        tick();
        vectors++;
        if (ok !== 4'b0010 || dout_of(1) !== 32'h33334444) begin
            miscompares++;
            $display("[TB] FAIL same_cycle_fill: got ok=%b dout1=%h want ok=0010 dout1=33334444", ok, dout_of(1));
        end
    endtask

    task automatic test_loop_rst();
        set_addr(1, 22'h350);
        tick();
        vectors++;
        if (sdram_req !== 1'b1) begin miscompares++; $display("[TB] FAIL loop_pre_req: got %b want 1", sdram_req); end
        loop_rst = 1'b1;
        tick();
        loop_rst = 1'b0;
        vectors++;
        if (sdram_req !== 1'b0 || refresh_en !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL loop_state: got req=%b refresh=%b want req=0 refresh=1", sdram_req, refresh_en);
        end
        set_addr(1, 22'h300);
        tick();
        vectors++;
        if (ok !== 4'b0010 || sdram_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL loop_cache_kept: got ok=%b req=%b want ok=0010 req=0", ok, sdram_req);
        end
    endtask

    task automatic test_downloading();
        logic [AW-1:0] got;
        bit            to;
        cs = 4'b0001;
        set_addr(0, 22'h100);
        do_reset();
        serve(32'hCAFE0001, got, to);
        tick();
        vectors++;
        if (to || ok !== 4'b0001) begin miscompares++; $display("[TB] FAIL dl_prefill: got ok=%b timeout=%0d want 0001", ok, to); end
        set_addr(0, 22'h400);
        tick();
        sdram_ack = 1'b1;
        tick();
        sdram_ack   = 1'b0;
        downloading = 1'b1;
        tick();
        vectors++;
        if (sdram_req !== 1'b0 || ok !== 4'b0000 || refresh_en !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL dl_idle: got req=%b ok=%b refresh=%b want 0 0000 1", sdram_req, ok, refresh_en);
        end
        data_rdy  = 1'b1;
        data_read = 32'h55555555;
        tick();
        data_rdy = 1'b0;
        vectors++;
        if (dout_of(0) !== 32'hCAFE0001) begin miscompares++; $display("[TB] FAIL dl_rdy_ignored: got %h want cafe0001", dout_of(0)); end
        set_addr(0, 22'h100);
        downloading = 1'b0;
        tick();
        vectors++;
        if (ok !== 4'b0000 || sdram_req !== 1'b1 || sdram_addr !== 22'h100) begin
            miscompares++;
            $display("[TB] FAIL dl_cache_flushed: got ok=%b req=%b addr=%h want 0000 1 00100", ok, sdram_req, sdram_addr);
        end
    endtask

    task automatic test_reset_mid();
        cs = 4'b0000;
        do_reset();
        data_rdy  = 1'b1;
        data_read = 32'h77777777;
        tick();
        data_rdy = 1'b0;
        vectors++;
        if (dout_of(0) !== 32'h0 || sdram_req !== 1'b0 || ok !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL late_rdy: got dout0=%h req=%b ok=%b want 0 0 0000", dout_of(0), sdram_req, ok);
        end
    endtask

    task automatic test_refresh_en();
        cs = 4'b0000;
        do_reset();
        tick();
        vectors++;
        if (refresh_en !== 1'b1) begin miscompares++; $display("[TB] FAIL ref_idle: got %b want 1", refresh_en); end
        cs = 4'b0001;
        set_addr(0, 22'h500);
        tick();
        vectors++;
        if (refresh_en !== 1'b0) begin miscompares++; $display("[TB] FAIL ref_issue: got %b want 0", refresh_en); end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        vectors++;
        if (refresh_en !== 1'b0) begin miscompares++; $display("[TB] FAIL ref_wait_rdy: got %b want 0", refresh_en); end
        data_rdy  = 1'b1;
        data_read = 32'h0BADF00D;
        tick();
        data_rdy = 1'b0;
        vectors++;
        if (refresh_en !== 1'b0) begin miscompares++; $display("[TB] FAIL ref_fill_edge: got %b want 0", refresh_en); end
        tick();
        vectors++;
        if (refresh_en !== 1'b1 || ok !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL ref_back: got refresh=%b ok=%b want 1 0001", refresh_en, ok);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        downloading = 1'b0;
        loop_rst    = 1'b0;
        sdram_ack   = 1'b0;
        data_rdy    = 1'b0;
        test_reset();
        test_miss_fill();
        test_hit_reuse();
        test_round_robin();
        test_addr_change();
        test_loop_rst();
        test_downloading();
        test_reset_mid();
        test_refresh_en();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
